// File: rtl/sdram_client_arbiter.sv
// Four-client SDRAM command-port arbiter: edge-captured requests, fixed priority with aging,
// READY-fall/READY-rise strobe handshake and timeout abort. Optional statistics: SDRAM_ARB_STATS_EN.
module sdram_client_arbiter #(
  parameter int unsigned AGE_LIMIT  = 6,
  parameter int unsigned WAIT_W     = 4,
  parameter int unsigned TIMEOUT    = 63,
  parameter logic [3:0]  WR_MASK    = 4'b1000,
  parameter logic [3:0]  BURST_MASK = 4'b0010
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic [3:0]          REQ,
  input  logic [3:0]          EN,
  input  logic                SDRAM_READY,
  output logic                SDRAM_RD,
  output logic                SDRAM_WR,
  output logic                SDRAM_BURST,
  output logic [1:0]          SEL,
  output logic                BUSY,
  output logic [3:0]          DONE,
  output logic                ERR,
  output logic [3:0]          PEND
`ifdef SDRAM_ARB_STATS_EN
  ,
  input  logic                STATS_CLR,
  output logic [63:0]         GRANT_CNT,
  output logic [4*WAIT_W-1:0] MAX_WAIT
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_BUSY
  } state_t;

  localparam int unsigned        TMO_W       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0]  LP_AGE      = WAIT_W'(AGE_LIMIT);
  localparam logic [WAIT_W-1:0]  LP_SAT      = '1;
  localparam logic [TMO_W-1:0]   LP_TMO_LAST = TMO_W'(TIMEOUT - 1);

  state_t            r_state;
  logic [3:0]        r_req_q;
  logic [3:0]        r_pend;
  logic [WAIT_W-1:0] r_wait [4];
  logic [TMO_W-1:0]  r_tmo;
  logic              r_rd;
  logic              r_wr;
  logic              r_burst;
  logic [1:0]        r_sel;
  logic              r_busy;
  logic [3:0]        r_done;
  logic              r_err;

  logic [3:0]        w_edge;
  logic [3:0]        w_urgent;
  logic              w_grant;
  logic [1:0]        w_win;
  logic [3:0]        w_grant_vec;

  function automatic logic [1:0] f_lowest(input logic [3:0] v);
    if (v[0])      return 2'd0;
    else if (v[1]) return 2'd1;
    else if (v[2]) return 2'd2;
    else           return 2'd3;
  endfunction

  for (genvar g = 0; g < 4; g++) begin : g_client
    assign w_urgent[g] = r_pend[g] && (r_wait[g] >= LP_AGE);

    always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
        r_wait[g] <= '0;
      end else if (w_grant_vec[g]) begin
        r_wait[g] <= '0;
      end else if (r_pend[g] && (r_wait[g] != LP_SAT)) begin
        r_wait[g] <= r_wait[g] + 1'b1;
      end
    end
  end

  always_comb begin
    w_edge      = REQ & ~r_req_q & EN;
    w_grant     = (r_state == ST_IDLE) && SDRAM_READY && (r_pend != '0);
    w_win       = (w_urgent != '0) ? f_lowest(w_urgent) : f_lowest(r_pend);
    w_grant_vec = w_grant ? (4'b0001 << w_win) : '0;
  end

  // A fresh edge in the grant cycle re-arms the pending bit the grant is clearing.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_req_q <= '0;
      r_pend  <= '0;
    end else begin
      r_req_q <= REQ;
      r_pend  <= (r_pend & ~w_grant_vec) | w_edge;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state <= ST_IDLE;
      r_tmo   <= '0;
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
      r_burst <= 1'b0;
      r_sel   <= '0;
      r_busy  <= 1'b0;
      r_done  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_done <= '0;
      r_err  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_grant) begin
            r_sel   <= w_win;
            r_wr    <= WR_MASK[w_win];
            r_rd    <= ~WR_MASK[w_win];
            r_burst <= BURST_MASK[w_win] & ~WR_MASK[w_win];
            r_busy  <= 1'b1;
            r_tmo   <= '0;
            r_state <= ST_ISSUE;
          end
        end
        ST_ISSUE, ST_BUSY: begin
          // Completion wins over a timeout landing in the same cycle.
          if ((r_state == ST_BUSY) && SDRAM_READY) begin
            r_done  <= 4'b0001 << r_sel;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else if (r_tmo == LP_TMO_LAST) begin
            r_rd    <= 1'b0;
            r_wr    <= 1'b0;
            r_burst <= 1'b0;
            r_err   <= 1'b1;
            r_done  <= 4'b0001 << r_sel;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            r_tmo <= r_tmo + 1'b1;
            if ((r_state == ST_ISSUE) && !SDRAM_READY) begin
              r_rd    <= 1'b0;
              r_wr    <= 1'b0;
              r_burst <= 1'b0;
              r_state <= ST_BUSY;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign SDRAM_RD    = r_rd;
  assign SDRAM_WR    = r_wr;
  assign SDRAM_BURST = r_burst;
  assign SEL         = r_sel;
  assign BUSY        = r_busy;
  assign DONE        = r_done;
  assign ERR         = r_err;
  assign PEND        = r_pend;

`ifdef SDRAM_ARB_STATS_EN
  logic [15:0]       r_gcnt [4];
  logic [WAIT_W-1:0] r_maxw [4];

  for (genvar s = 0; s < 4; s++) begin : g_stats
    always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
        r_gcnt[s] <= '0;
        r_maxw[s] <= '0;
      end else if (STATS_CLR) begin
        r_gcnt[s] <= '0;
        r_maxw[s] <= '0;
      end else begin
        if (w_grant_vec[s] && (r_gcnt[s] != 16'hFFFF)) begin
          r_gcnt[s] <= r_gcnt[s] + 1'b1;
        end
        if (r_wait[s] > r_maxw[s]) begin
          r_maxw[s] <= r_wait[s];
        end
      end
    end

    assign GRANT_CNT[s*16 +: 16]        = r_gcnt[s];
    assign MAX_WAIT[s*WAIT_W +: WAIT_W] = r_maxw[s];
  end
`endif

endmodule

// File: tb/tb_sdram_client_arbiter.sv
// Self-checking bench for sdram_client_arbiter: directed scenarios plus randomized traffic
// compared against a transaction-level reference model.
module tb_sdram_client_arbiter;

  localparam int         TB_AGE     = 6;
  localparam int         TB_WMAX    = 15;
  localparam int         TB_TIMEOUT = 63;
  localparam logic [3:0] TB_WR      = 4'b1000;
  localparam logic [3:0] TB_BURST   = 4'b0010;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic [3:0] REQ = '0;
  logic [3:0] EN = '1;
  logic       SDRAM_READY = 1'b1;
  logic       SDRAM_RD, SDRAM_WR, SDRAM_BURST, BUSY, ERR;
  logic [1:0] SEL;
  logic [3:0] DONE, PEND;

  int n_tests = 0;
  int n_fail  = 0;

  sdram_client_arbiter #(
    .AGE_LIMIT (TB_AGE),
    .WAIT_W    (4),
    .TIMEOUT   (TB_TIMEOUT),
    .WR_MASK   (TB_WR),
    .BURST_MASK(TB_BURST)
  ) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .REQ        (REQ),
    .EN         (EN),
    .SDRAM_READY(SDRAM_READY),
    .SDRAM_RD   (SDRAM_RD),
    .SDRAM_WR   (SDRAM_WR),
    .SDRAM_BURST(SDRAM_BURST),
    .SEL        (SEL),
    .BUSY       (BUSY),
    .DONE       (DONE),
    .ERR        (ERR),
    .PEND       (PEND)
  );

  always #5 CLK = ~CLK;

  // Reference model: phase 0 = free, 1 = strobe out waiting for READY low, 2 = waiting for READY high.
  int       m_phase, m_sel, m_elapsed, m_gnt;
  int       m_age [4];
  bit       m_pend [4];
  bit       m_prev [4];
  bit       m_edge [4];
  bit       m_rd, m_wr, m_burst, m_busy, m_err, m_any;
  bit [3:0] m_done;
  bit [3:0] m_pendv;

  always @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      m_phase = 0; m_sel = 0; m_elapsed = 0;
      m_rd = 0; m_wr = 0; m_burst = 0; m_busy = 0; m_err = 0; m_done = '0;
      for (int i = 0; i < 4; i++) begin
        m_age[i] = 0; m_pend[i] = 0; m_prev[i] = 0;
      end
    end else begin
      m_gnt = -1; m_done = '0; m_err = 0; m_any = 0;
      for (int i = 0; i < 4; i++) begin
        m_edge[i] = REQ[i] && !m_prev[i] && EN[i];
        if (m_pend[i]) m_any = 1;
      end
      if (m_phase == 0) begin
        if (SDRAM_READY && m_any) begin
          for (int i = 0; i < 4; i++)
            if (m_gnt < 0 && m_pend[i] && m_age[i] >= TB_AGE) m_gnt = i;
          for (int i = 0; i < 4; i++)
            if (m_gnt < 0 && m_pend[i]) m_gnt = i;
          m_sel = m_gnt;
          m_wr = TB_WR[m_gnt];
          m_rd = !TB_WR[m_gnt];
          m_burst = TB_BURST[m_gnt] && !TB_WR[m_gnt];
          m_busy = 1; m_phase = 1; m_elapsed = 0;
        end
      end else begin
        m_elapsed++;
        if (m_phase == 2 && SDRAM_READY) begin
          m_done[m_sel] = 1; m_busy = 0; m_phase = 0;
        end else if (m_elapsed >= TB_TIMEOUT) begin
          m_rd = 0; m_wr = 0; m_burst = 0; m_err = 1;
          m_done[m_sel] = 1; m_busy = 0; m_phase = 0;
        end else if (m_phase == 1 && !SDRAM_READY) begin
          m_rd = 0; m_wr = 0; m_burst = 0; m_phase = 2;
        end
      end
      for (int i = 0; i < 4; i++) begin
        if (m_gnt == i) m_age[i] = 0;
        else if (m_pend[i] && m_age[i] < TB_WMAX) m_age[i]++;
        if (m_edge[i]) m_pend[i] = 1;
        else if (m_gnt == i) m_pend[i] = 0;
        m_prev[i] = REQ[i];
      end
    end
  end

  task automatic apply_reset();
    REQ = '0; EN = '1; SDRAM_READY = 1'b1; RESET = 1'b1;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
  endtask

  task automatic test_reset();
    RESET = 1'b1; REQ = '0;
    @(negedge CLK);
    n_tests++;
    if ({SDRAM_RD, SDRAM_WR, SDRAM_BURST, BUSY, ERR} !== 5'b0) begin
      n_fail++; $display("FAIL reset_strobes got %b want 00000", {SDRAM_RD, SDRAM_WR, SDRAM_BURST, BUSY, ERR});
    end
    n_tests++;
    if (SEL !== 2'd0 || DONE !== 4'd0 || PEND !== 4'd0) begin
      n_fail++; $display("FAIL reset_sel_done_pend got %h %h %h want 0 0 0", SEL, DONE, PEND);
    end
    RESET = 1'b0;
  endtask

  task automatic test_single_crom();
    apply_reset();
    REQ = 4'b0010;
    @(negedge CLK);
    n_tests++;
    if (PEND !== 4'b0010 || SDRAM_RD !== 1'b0) begin
      n_fail++; $display("FAIL crom_pend got pend=%b rd=%b want 0010 0", PEND, SDRAM_RD);
    end
    @(negedge CLK);
    n_tests++;
    if ({SDRAM_RD, SDRAM_WR, SDRAM_BURST, BUSY} !== 4'b1011 || SEL !== 2'd1) begin
      n_fail++; $display("FAIL crom_issue got rd/wr/bu/busy=%b sel=%0d want 1011 1",
                         {SDRAM_RD, SDRAM_WR, SDRAM_BURST, BUSY}, SEL);
    end
    SDRAM_READY = 1'b0;
    @(negedge CLK);
    n_tests++;
    if (SDRAM_RD !== 1'b0 || BUSY !== 1'b1 || DONE !== 4'b0) begin
      n_fail++; $display("FAIL crom_busy got rd=%b busy=%b done=%b want 0 1 0000", SDRAM_RD, BUSY, DONE);
    end
    SDRAM_READY = 1'b1;
    @(negedge CLK);
    n_tests++;
    if (DONE !== 4'b0010 || BUSY !== 1'b0 || SEL !== 2'd1) begin
      n_fail++; $display("FAIL crom_done got done=%b busy=%b sel=%0d want 0010 0 1", DONE, BUSY, SEL);
    end
    @(negedge CLK);
    n_tests++;
    if (DONE !== 4'b0) begin
      n_fail++; $display("FAIL crom_done_width got %b want 0000", DONE);
    end
    REQ = '0;
  endtask

  task automatic test_simultaneous();
    apply_reset();
    REQ = 4'b0101;
    @(negedge CLK);
    n_tests++;
    if (PEND !== 4'b0101) begin
      n_fail++; $display("FAIL simul_pend got %b want 0101", PEND);
    end
    @(negedge CLK);
    n_tests++;
    if (SEL !== 2'd0 || SDRAM_RD !== 1'b1 || PEND !== 4'b0100) begin
      n_fail++; $display("FAIL simul_first got sel=%0d rd=%b pend=%b want 0 1 0100", SEL, SDRAM_RD, PEND);
    end
    SDRAM_READY = 1'b0;
    @(negedge CLK);
    SDRAM_READY = 1'b1;
    @(negedge CLK);
    n_tests++;
    if (DONE !== 4'b0001) begin
      n_fail++; $display("FAIL simul_done0 got %b want 0001", DONE);
    end
    @(negedge CLK);
    n_tests++;
    if (SEL !== 2'd2 || SDRAM_RD !== 1'b1 || SDRAM_BURST !== 1'b0) begin
      n_fail++; $display("FAIL simul_second got sel=%0d rd=%b burst=%b want 2 1 0", SEL, SDRAM_RD, SDRAM_BURST);
    end
    SDRAM_READY = 1'b0;
    @(negedge CLK);
    SDRAM_READY = 1'b1;
    @(negedge CLK);
    n_tests++;
    if (DONE !== 4'b0100) begin
      n_fail++; $display("FAIL simul_done2 got %b want 0100", DONE);
    end
    REQ = '0;
  endtask

  task automatic test_aging();
    logic [1:0] exp_sel;
    logic [3:0] exp_done;
    apply_reset();
    REQ = 4'b0011;
    @(negedge CLK);
    for (int k = 0; k < 3; k++) begin
      exp_sel  = (k == 2) ? 2'd1 : 2'd0;
      exp_done = (k == 2) ? 4'b0010 : 4'b0001;
      @(negedge CLK);
      n_tests++;
      if (SEL !== exp_sel || SDRAM_RD !== 1'b1) begin
        n_fail++; $display("FAIL aging_grant%0d got sel=%0d rd=%b want %0d 1", k, SEL, SDRAM_RD, exp_sel);
      end
      if (k == 2) begin
        n_tests++;
        if (PEND !== 4'b0001) begin
          n_fail++; $display("FAIL aging_m68k_waiting got %b want 0001", PEND);
        end
      end
      REQ[0] = 1'b0; SDRAM_READY = 1'b0;
      @(negedge CLK);
      REQ[0] = 1'b1; SDRAM_READY = 1'b1;
      @(negedge CLK);
      n_tests++;
      if (DONE !== exp_done) begin
        n_fail++; $display("FAIL aging_done%0d got %b want %b", k, DONE, exp_done);
      end
    end
    REQ = '0;
  endtask

  task automatic test_cd_write();
    apply_reset();
    REQ = 4'b1000;
    repeat (2) @(negedge CLK);
    n_tests++;
    if ({SDRAM_WR, SDRAM_RD, SDRAM_BURST} !== 3'b100 || SEL !== 2'd3) begin
      n_fail++; $display("FAIL cdwr_issue got wr/rd/bu=%b sel=%0d want 100 3",
                         {SDRAM_WR, SDRAM_RD, SDRAM_BURST}, SEL);
    end
    SDRAM_READY = 1'b0;
    @(negedge CLK);
    SDRAM_READY = 1'b1;
    @(negedge CLK);
    n_tests++;
    if (DONE !== 4'b1000 || SDRAM_WR !== 1'b0) begin
      n_fail++; $display("FAIL cdwr_done got done=%b wr=%b want 1000 0", DONE, SDRAM_WR);
    end
    REQ = '0;
  endtask

  task automatic test_rerequest();
    apply_reset();
    REQ = 4'b0010; SDRAM_READY = 1'b0;
    @(negedge CLK);
    REQ = 4'b0000;
    @(negedge CLK);
    REQ = 4'b0010; SDRAM_READY = 1'b1;
    @(negedge CLK);
    n_tests++;
    if (PEND !== 4'b0010 || SEL !== 2'd1 || SDRAM_RD !== 1'b1) begin
      n_fail++; $display("FAIL rereq_grant got pend=%b sel=%0d rd=%b want 0010 1 1", PEND, SEL, SDRAM_RD);
    end
    SDRAM_READY = 1'b0;
    @(negedge CLK);
    SDRAM_READY = 1'b1;
    @(negedge CLK);
    n_tests++;
    if (DONE !== 4'b0010) begin
      n_fail++; $display("FAIL rereq_done1 got %b want 0010", DONE);
    end
    @(negedge CLK);
    n_tests++;
    if (SDRAM_RD !== 1'b1 || SEL !== 2'd1 || PEND !== 4'b0000) begin
      n_fail++; $display("FAIL rereq_second got rd=%b sel=%0d pend=%b want 1 1 0000", SDRAM_RD, SEL, PEND);
    end
    SDRAM_READY = 1'b0;
    @(negedge CLK);
    SDRAM_READY = 1'b1;
    @(negedge CLK);
    n_tests++;
    if (DONE !== 4'b0010) begin
      n_fail++; $display("FAIL rereq_done2 got %b want 0010", DONE);
    end
    REQ = '0;
  endtask

  task automatic test_timeout();
    int cyc;
    bit seen;
    apply_reset();
    REQ = 4'b0001;
    repeat (2) @(negedge CLK);
    SDRAM_READY = 1'b0;
    cyc = 0; seen = 0;
    while (!seen && cyc < 100) begin
      @(negedge CLK);
      cyc++;
      if (ERR === 1'b1) seen = 1;
    end
    n_tests++;
    if (!seen || cyc != TB_TIMEOUT) begin
      n_fail++; $display("FAIL timeout_latency got seen=%0d cycles=%0d want 1 %0d", seen, cyc, TB_TIMEOUT);
    end
    n_tests++;
    if (DONE !== 4'b0001 || BUSY !== 1'b0 || SDRAM_RD !== 1'b0) begin
      n_fail++; $display("FAIL timeout_done got done=%b busy=%b rd=%b want 0001 0 0", DONE, BUSY, SDRAM_RD);
    end
    SDRAM_READY = 1'b1;
    @(negedge CLK);
    n_tests++;
    if (ERR !== 1'b0 || DONE !== 4'b0 || PEND !== 4'b0 || SDRAM_RD !== 1'b0) begin
      n_fail++; $display("FAIL timeout_after got err=%b done=%b pend=%b rd=%b want 0 0000 0000 0",
                         ERR, DONE, PEND, SDRAM_RD);
    end
    REQ = '0;
  endtask

  task automatic test_reset_mid();
    apply_reset();
    REQ = 4'b0101;
    repeat (2) @(negedge CLK);
    n_tests++;
    if (SDRAM_RD !== 1'b1 || PEND !== 4'b0100) begin
      n_fail++; $display("FAIL rstmid_setup got rd=%b pend=%b want 1 0100", SDRAM_RD, PEND);
    end
    #2 RESET = 1'b1;
    #1;
    n_tests++;
    if (SDRAM_RD !== 1'b0 || SDRAM_WR !== 1'b0 || PEND !== 4'b0 || BUSY !== 1'b0 || SEL !== 2'd0) begin
      n_fail++; $display("FAIL rstmid_async got rd=%b wr=%b pend=%b busy=%b sel=%0d want 0 0 0000 0 0",
                         SDRAM_RD, SDRAM_WR, PEND, BUSY, SEL);
    end
    REQ = '0;
    @(negedge CLK);
    RESET = 1'b0;
  endtask

  task automatic test_random();
    apply_reset();
    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(negedge CLK);
      for (int i = 0; i < 4; i++) m_pendv[i] = m_pend[i];
      n_tests++;
      if ({SDRAM_RD, SDRAM_WR, SDRAM_BURST, BUSY} !== {m_rd, m_wr, m_burst, m_busy}) begin
        n_fail++; $display("FAIL rand_strobes cyc=%0d got %b want %b", cyc,
                           {SDRAM_RD, SDRAM_WR, SDRAM_BURST, BUSY}, {m_rd, m_wr, m_burst, m_busy});
      end
      n_tests++;
      if (SEL !== m_sel[1:0]) begin
        n_fail++; $display("FAIL rand_sel cyc=%0d got %0d want %0d", cyc, SEL, m_sel);
      end
      n_tests++;
      if (DONE !== m_done || ERR !== m_err) begin
        n_fail++; $display("FAIL rand_done cyc=%0d got done=%b err=%b want %b %b", cyc, DONE, ERR, m_done, m_err);
      end
      n_tests++;
      if (PEND !== m_pendv) begin
        n_fail++; $display("FAIL rand_pend cyc=%0d got %b want %b", cyc, PEND, m_pendv);
      end
      n_tests++;
      if ((SDRAM_RD & SDRAM_WR) !== 1'b0) begin
        n_fail++; $display("FAIL rand_exclusive cyc=%0d got rd=%b wr=%b want not both", cyc, SDRAM_RD, SDRAM_WR);
      end
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(0, 2) == 0) REQ[i] = ~REQ[i];
        EN[i] = ($urandom_range(0, 3) != 0);
      end
      if ((cyc % 400) >= 300 && (cyc % 400) < 380) SDRAM_READY = 1'b0;
      else SDRAM_READY = ($urandom_range(0, 3) != 0);
    end
    REQ = '0; EN = '1; SDRAM_READY = 1'b1;
  endtask

  initial begin
    test_reset();
    test_single_crom();
    test_simultaneous();
    test_aging();
    test_cd_write();
    test_rerequest();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
